// File: rtl/fifo_write_relay_pkg.sv
// Shared constants and elaboration helpers for the pipelined FIFO write relay.
package fifo_write_relay_pkg;

  localparam int MAX_LEVEL = 8;

  // The FIFO grace slots must absorb every write that can still be in flight.
  function automatic bit grace_covers_level(input int level, input int grace);
    return (2 * level) <= grace;
  endfunction

endpackage

// File: rtl/relay_shift_reg.sv
// Async-reset shift register, one word per stage, with an OR of the top bit
// across all stages (the forward pipe uses it as "any write in flight").
module relay_shift_reg
  import fifo_write_relay_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             msb_any
);

  if (DEPTH < 1 || DEPTH > MAX_LEVEL) begin : g_depth_check
    $error("relay_shift_reg: DEPTH must be within 1..MAX_LEVEL");
  end

  logic [DEPTH-1:0][WIDTH-1:0] regs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= {DEPTH{RESET_VAL}};
    end else begin
      regs[0] <= d;
      for (int k = 1; k < DEPTH; k++) begin
        regs[k] <= regs[k-1];
      end
    end
  end

  always_comb begin
    msb_any = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      msb_any = msb_any | regs[k][WIDTH-1];
    end
  end

  assign q = regs[DEPTH-1];

endmodule

// File: rtl/fifo_write_relay.sv
// Producer-side relay: LEVEL register stages on write/data towards an
// almost-full FIFO, LEVEL stages on full_n back, plus a grace-overrun monitor.
module fifo_write_relay
  import fifo_write_relay_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int LEVEL        = 2,
  parameter int GRACE_PERIOD = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  out_write,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full_n,
  output logic                  idle,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  excess_cnt
);

  if (LEVEL < 1 || LEVEL > MAX_LEVEL) begin : g_level_check
    $error("fifo_write_relay: LEVEL must be within 1..MAX_LEVEL");
  end

  if (!grace_covers_level(LEVEL, GRACE_PERIOD)) begin : g_grace_check
    $error("fifo_write_relay: GRACE_PERIOD must be at least 2*LEVEL");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH:0] fwd_q;
  logic                fwd_valid_any;
  logic                bwd_any_unused;

  // The write strobe rides as the MSB so the stage OR doubles as "busy".
  relay_shift_reg #(
    .WIDTH    (DATA_WIDTH + 1),
    .DEPTH    (LEVEL),
    .RESET_VAL('0)
  ) u_fwd (
    .clk    (clk),
    .reset  (reset),
    .d      ({if_write, if_din}),
    .q      (fwd_q),
    .msb_any(fwd_valid_any)
  );

  relay_shift_reg #(
    .WIDTH    (1),
    .DEPTH    (LEVEL),
    .RESET_VAL(1'b1)
  ) u_bwd (
    .clk    (clk),
    .reset  (reset),
    .d      (out_full_n),
    .q      (if_full_n),
    .msb_any(bwd_any_unused)
  );

  assign out_write = fwd_q[DATA_WIDTH];
  assign out_din   = fwd_q[DATA_WIDTH-1:0];
  assign idle      = ~fwd_valid_any;

  // Counts writes landing while the FIFO is past its threshold; one more than
  // the grace slots means a word was dropped by the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      excess_cnt <= '0;
      overflow   <= 1'b0;
    end else if (out_full_n) begin
      excess_cnt <= '0;
    end else if (out_write) begin
      if (excess_cnt != CNT_MAX) begin
        excess_cnt <= excess_cnt + 1'b1;
      end
      if (int'(excess_cnt) >= GRACE_PERIOD) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_relay.sv
// Randomized bench for fifo_write_relay (LEVEL=2 and LEVEL=3 side by side)
// against a history-based reference model and a behavioural FWFT FIFO.
module tb_fifo_write_relay;

  localparam int DW       = 32;
  localparam int CW       = 8;
  localparam int NWORDS   = 10000;
  localparam int FDEPTH   = 32;
  localparam int AF_LEVEL = 28;
  localparam int LV [2]   = '{2, 3};
  localparam int GP [2]   = '{4, 6};
  localparam int CNT_SAT  = 255;

  logic                clk = 1'b0;
  logic                reset;
  logic                if_write;
  logic [DW-1:0]       if_din;
  logic                out_full_n;
  logic [1:0]          ifn, ow, idl, ovf;
  logic [1:0][DW-1:0]  od;
  logic [1:0][CW-1:0]  ec;

  fifo_write_relay #(.DATA_WIDTH(DW), .LEVEL(2), .GRACE_PERIOD(4), .CNT_WIDTH(CW)) dut_l2 (
    .clk(clk), .reset(reset), .if_full_n(ifn[0]), .if_write(if_write), .if_din(if_din),
    .out_write(ow[0]), .out_din(od[0]), .out_full_n(out_full_n), .idle(idl[0]),
    .overflow(ovf[0]), .excess_cnt(ec[0])
  );

  fifo_write_relay #(.DATA_WIDTH(DW), .LEVEL(3), .GRACE_PERIOD(6), .CNT_WIDTH(CW)) dut_l3 (
    .clk(clk), .reset(reset), .if_full_n(ifn[1]), .if_write(if_write), .if_din(if_din),
    .out_write(ow[1]), .out_din(od[1]), .out_full_n(out_full_n), .idle(idl[1]),
    .overflow(ovf[1]), .excess_cnt(ec[1])
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Input history since the last reset release; entry i is what the DUT saw
  // at the (i+1)th rising edge.
  logic          wr_q [$];
  logic [DW-1:0] din_q [$];
  logic          fn_q [$];
  int            m_cnt [2];
  logic          m_ovf [2];

  logic          fifo_mode = 1'b0;
  logic          fifo_rd   = 1'b0;
  logic          cap_w     = 1'b0;
  logic [DW-1:0] cap_d     = '0;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] src_q [$];
  int            received, drops;

  logic [DW-1:0] lat_data [3] = '{32'h11, 32'h22, 32'h33};
  logic          lat_w    [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic          lat_i    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_write(input int l);
    int n = wr_q.size();
    return (n >= l) ? wr_q[n-l] : 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_din(input int l);
    int n = din_q.size();
    return (n >= l) ? din_q[n-l] : '0;
  endfunction

  function automatic logic m_fulln(input int l);
    int n = fn_q.size();
    return (n >= l) ? fn_q[n-l] : 1'b1;
  endfunction

  // Idle when none of the last l accepted-edge samples carried a write.
  function automatic logic m_idle(input int l);
    int n = wr_q.size();
    for (int k = 1; k <= l; k++) begin
      if (n - k >= 0 && wr_q[n-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (out_full_n) begin
        m_cnt[i] = 0;
      end else if (m_write(LV[i])) begin
        if (m_cnt[i] + 1 > GP[i]) m_ovf[i] = 1'b1;
        m_cnt[i] = (m_cnt[i] + 1 > CNT_SAT) ? CNT_SAT : m_cnt[i] + 1;
      end
    end
    wr_q.push_back(if_write);
    din_q.push_back(if_din);
    fn_q.push_back(out_full_n);
  endtask

  task automatic model_reset();
    wr_q.delete();
    din_q.delete();
    fn_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("%s_write_l%0d", ph, LV[i]), 64'(ow[i]), 64'(m_write(LV[i])));
      check_output($sformatf("%s_din_l%0d", ph, LV[i]), 64'(od[i]), 64'(m_din(LV[i])));
      check_output($sformatf("%s_fulln_l%0d", ph, LV[i]), 64'(ifn[i]), 64'(m_fulln(LV[i])));
      check_output($sformatf("%s_idle_l%0d", ph, LV[i]), 64'(idl[i]), 64'(m_idle(LV[i])));
      check_output($sformatf("%s_ovf_l%0d", ph, LV[i]), 64'(ovf[i]), 64'(m_ovf[i]));
      check_output($sformatf("%s_cnt_l%0d", ph, LV[i]), 64'(ec[i]), 64'(m_cnt[i]));
    end
  endtask

  task automatic fifo_edge();
    logic [DW-1:0] got, exp;
    if (fifo_rd) begin
      got = fifo_q.pop_front();
      exp = (src_q.size() > 0) ? src_q.pop_front() : 'x;
      check_output("fifo_data", 64'(got), 64'(exp));
      received++;
    end
    if (cap_w) begin
      if (fifo_q.size() >= FDEPTH) drops++;
      else fifo_q.push_back(cap_d);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge after checking.
  task automatic apply_stimulus(input logic wr, input logic [DW-1:0] d, input logic fl, input string ph);
    if_write   = wr;
    if_din     = d;
    out_full_n = fl;
    cap_w      = ow[0];
    cap_d      = od[0];
    @(posedge clk);
    model_edge();
    if (fifo_mode) fifo_edge();
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic do_reset();
    if_write = 1'b0;
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic grace_run(input int extra);
    int   extra_used = 0;
    logic wr;
    for (int k = 0; k < 20; k++) begin
      if (ifn[0]) wr = 1'b1;
      else if (extra_used < extra) begin
        wr = 1'b1;
        extra_used++;
      end else wr = 1'b0;
      apply_stimulus(wr, $urandom, (k < 6), "grace");
    end
    check_output("grace_cnt", 64'(ec[0]), (extra == 0) ? 64'd4 : 64'd7);
    check_output("grace_ovf", 64'(ovf[0]), 64'(extra > 0));
    apply_stimulus(1'b0, $urandom, 1'b1, "grace_rel");
    check_output("grace_cnt_clr", 64'(ec[0]), 64'd0);
    check_output("grace_ovf_sticky", 64'(ovf[0]), 64'(extra > 0));
  endtask

  initial begin
    logic          wr;
    logic [DW-1:0] d;
    int            sent;

    reset      = 1'b0;
    if_write   = 1'b0;
    if_din     = '0;
    out_full_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("por");
    reset = 1'b1;

    $display("[TB] latency and throughput");
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(k < 3, (k < 3) ? lat_data[k] : 32'h0, 1'b1, "lat");
      check_output("lat_write", 64'(ow[0]), 64'(lat_w[k]));
      check_output("lat_idle", 64'(idl[0]), 64'(lat_i[k]));
      if (lat_w[k]) check_output("lat_data", 64'(od[0]), 64'(lat_data[k-1]));
    end

    $display("[TB] backpressure delay");
    for (int k = 0; k < 26; k++) begin
      apply_stimulus($urandom_range(0, 1) == 1, $urandom, !(k >= 10 && k < 20), "bp");
      check_output("bp_fulln_l2", 64'(ifn[0]), 64'(!((k - 1) >= 10 && (k - 1) < 20)));
      check_output("bp_fulln_l3", 64'(ifn[1]), 64'(!((k - 2) >= 10 && (k - 2) < 20)));
    end

    $display("[TB] grace within limits / overflow");
    do_reset();
    grace_run(0);
    do_reset();
    grace_run(3);
    do_reset();

    $display("[TB] toggling full_n and random traffic");
    for (int k = 0; k < 40; k++) begin
      apply_stimulus($urandom_range(0, 1) == 1, $urandom, (k % 2) == 0, "tog");
    end
    for (int k = 0; k < 200; k++) begin
      apply_stimulus($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0, "rnd");
    end

    $display("[TB] reset with writes in flight");
    apply_stimulus(1'b1, $urandom, 1'b1, "pre_rst");
    apply_stimulus(1'b1, $urandom, 1'b1, "pre_rst");
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0, $urandom, 1'b1, "post_rst");
    end

    $display("[TB] relay into behavioural FIFO");
    fifo_mode = 1'b1;
    sent      = 0;
    received  = 0;
    drops     = 0;
    for (int cyc = 0; cyc < 60000 && received < NWORDS; cyc++) begin
      wr = ifn[0] && (sent < NWORDS) && ($urandom_range(0, 3) != 0);
      d  = $urandom;
      if (wr) begin
        src_q.push_back(d);
        sent++;
      end
      fifo_rd = (fifo_q.size() > 0) && ($urandom_range(0, 2) != 0);
      apply_stimulus(wr, d, fifo_q.size() < AF_LEVEL, "fifo");
    end
    check_output("fifo_words", 64'(received), 64'(NWORDS));
    check_output("fifo_drops", 64'(drops), 64'd0);
    check_output("fifo_ovf", 64'(ovf[0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
